// File: rtl/sm83_bus_pkg.sv
// Shared types and constants for the SM83-style bus arbiter.
package sm83_bus_pkg;

  localparam int unsigned T_PER_M = 4;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4
  } bus_state_e;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } requester_e;

  // Transfer captured at an arbitration edge and replayed over T1..T4.
  typedef struct packed {
    requester_e          owner;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } xfer_t;

  // T-states in which the read/write strobes are active.
  function automatic logic is_strobe_phase(input bus_state_e s);
    return (s == T2) || (s == T3) || (s == T4);
  endfunction

endpackage

// File: rtl/sm83_bus_arb_if.sv
// Requester handshakes plus external bus pins of the arbiter.
interface sm83_bus_arb_if;
  import sm83_bus_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rd;
  logic              bus_wr;
  logic              bus_data_oe;
  logic [DATA_W-1:0] bus_rdata;

  // Requesters and the external memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output bus_rdata,
    input  cpu_gnt, cpu_done, dma_gnt, dma_done, rdata, busy,
    input  bus_addr, bus_wdata, bus_rd, bus_wr, bus_data_oe
  );

  // The arbiter itself.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  bus_rdata,
    output cpu_gnt, cpu_done, dma_gnt, dma_done, rdata, busy,
    output bus_addr, bus_wdata, bus_rd, bus_wr, bus_data_oe
  );

endinterface

// File: rtl/sm83_bus_arb_prio.sv
// Winner selection with a saturating CPU starvation counter.
module sm83_bus_arb_prio
  import sm83_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_arb_edge,
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  output logic       o_win_valid_c,
  output requester_e o_win_owner_c
);

  localparam int unsigned     CNT_W   = (STARVE_LIMIT > 7) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve;
  logic             w_cpu_turn;

  // CPU overrides DMA only once it has waited out STARVE_LIMIT DMA grants.
  always_comb begin
    w_cpu_turn    = (STARVE_LIMIT != 0) && i_cpu_req && (r_starve == LIMIT);
    o_win_valid_c = i_cpu_req || i_dma_req;
    o_win_owner_c = (i_dma_req && !w_cpu_turn) ? DMA : CPU;
  end

  // Count DMA grants taken while the CPU is waiting; clear when the CPU wins or stops asking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (i_arb_edge) begin
      if (!i_cpu_req || (o_win_owner_c == CPU)) begin
        r_starve <= '0;
      end else if (r_starve != CNT_MAX) begin
        r_starve <= r_starve + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sm83_bus_arb.sv
// CPU/DMA bus arbiter and T1..T4 M-cycle sequencer driving the external bus.
module sm83_bus_arb
  import sm83_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  sm83_bus_arb_if.slave bus
);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  xfer_t             r_xfer;
  xfer_t             w_xfer_nxt;

  logic              w_arb_edge;
  logic              w_capture;
  logic              w_win_valid;
  requester_e        w_win_owner;

  logic              r_cpu_gnt,  w_cpu_gnt_d;
  logic              r_dma_gnt,  w_dma_gnt_d;
  logic              r_cpu_done, w_cpu_done_d;
  logic              r_dma_done, w_dma_done_d;
  logic [DATA_W-1:0] r_rdata,    w_rdata_d;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_d;
  logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_d;
  logic              r_bus_rd,   w_bus_rd_d;
  logic              r_bus_wr,   w_bus_wr_d;
  logic              r_bus_oe,   w_bus_oe_d;
  logic              r_busy,     w_busy_d;

  assign w_arb_edge = (r_state == IDLE) || (r_state == T4);
  assign w_capture  = w_arb_edge && w_win_valid;

  sm83_bus_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_arb_edge    (w_arb_edge),
    .i_cpu_req     (bus.cpu_req),
    .i_dma_req     (bus.dma_req),
    .o_win_valid_c (w_win_valid),
    .o_win_owner_c (w_win_owner)
  );

  // Transfer that will be in flight after this edge.
  always_comb begin
    w_xfer_nxt = r_xfer;
    if (w_capture) begin
      if (w_win_owner == DMA) begin
        w_xfer_nxt = '{owner: DMA, we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
      end else begin
        w_xfer_nxt = '{owner: CPU, we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
      end
    end
  end

  // State register and captured transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_xfer  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_xfer  <= w_xfer_nxt;
    end
  end

  // Next state: T1..T4 run unconditionally; IDLE and T4 re-arbitrate.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = w_win_valid ? T1 : IDLE;
      T1:      w_state_nxt = T2;
      T2:      w_state_nxt = T3;
      T3:      w_state_nxt = T4;
      T4:      w_state_nxt = w_win_valid ? T1 : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of every output, decoded from the state being entered.
  always_comb begin
    w_cpu_gnt_d   = 1'b0;
    w_dma_gnt_d   = 1'b0;
    w_cpu_done_d  = 1'b0;
    w_dma_done_d  = 1'b0;
    w_rdata_d     = r_rdata;
    w_bus_addr_d  = '0;
    w_bus_wdata_d = '0;
    w_bus_rd_d    = 1'b0;
    w_bus_wr_d    = 1'b0;
    w_bus_oe_d    = 1'b0;
    w_busy_d      = (w_state_nxt != IDLE);
    if (w_capture) begin
      w_cpu_gnt_d = (w_win_owner == CPU);
      w_dma_gnt_d = (w_win_owner == DMA);
    end
    if (w_state_nxt != IDLE) begin
      w_bus_addr_d  = w_xfer_nxt.addr;
      w_bus_wdata_d = w_xfer_nxt.wdata;
    end
    if (is_strobe_phase(w_state_nxt)) begin
      w_bus_rd_d = !w_xfer_nxt.we;
      w_bus_wr_d = w_xfer_nxt.we;
      w_bus_oe_d = w_xfer_nxt.we;
    end
    if (r_state == T4) begin
      w_cpu_done_d = (r_xfer.owner == CPU);
      w_dma_done_d = (r_xfer.owner == DMA);
      if (!r_xfer.we) begin
        w_rdata_d = bus.bus_rdata;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_gnt   <= 1'b0;
      r_dma_gnt   <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_rdata     <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_rd    <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_gnt   <= w_cpu_gnt_d;
      r_dma_gnt   <= w_dma_gnt_d;
      r_cpu_done  <= w_cpu_done_d;
      r_dma_done  <= w_dma_done_d;
      r_rdata     <= w_rdata_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_wdata <= w_bus_wdata_d;
      r_bus_rd    <= w_bus_rd_d;
      r_bus_wr    <= w_bus_wr_d;
      r_bus_oe    <= w_bus_oe_d;
      r_busy      <= w_busy_d;
    end
  end

  assign bus.cpu_gnt     = r_cpu_gnt;
  assign bus.dma_gnt     = r_dma_gnt;
  assign bus.cpu_done    = r_cpu_done;
  assign bus.dma_done    = r_dma_done;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = r_busy;
  assign bus.bus_addr    = r_bus_addr;
  assign bus.bus_wdata   = r_bus_wdata;
  assign bus.bus_rd      = r_bus_rd;
  assign bus.bus_wr      = r_bus_wr;
  assign bus.bus_data_oe = r_bus_oe;

endmodule
